// File: rtl/ibex_xif_multdiv_arbiter_if.sv
// ibex_xif_multdiv_arbiter_if: requester request/response channels and multdiv unit handshake
interface ibex_xif_multdiv_arbiter_if #(parameter int unsigned TagW = 3);
  logic [1:0]        req_valid_i, req_ready_o;
  logic [3:0]        req_operator_i, req_signed_mode_i;
  logic [63:0]       req_op_a_i, req_op_b_i;
  logic [2*TagW-1:0] req_tag_i;
  logic [1:0]        kill_i, rsp_valid_o, rsp_ready_i;
  logic [31:0]       rsp_result_o;
  logic [TagW-1:0]   rsp_tag_o;
  logic              md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
  logic [1:0]        md_operator_o, md_signed_mode_o;
  logic [31:0]       md_op_a_o, md_op_b_o;
  logic              md_data_ind_timing_o, md_ready_id_o, md_valid_i;
  logic [31:0]       md_result_i;
  logic              busy_o;
  modport slave (
    input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, req_tag_i,
           kill_i, rsp_ready_i, md_valid_i, md_result_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, md_mult_en_o, md_div_en_o,
           md_mult_sel_o, md_div_sel_o, md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o,
           md_data_ind_timing_o, md_ready_id_o, busy_o
  );
  modport master (
    output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i, req_tag_i,
           kill_i, rsp_ready_i, md_valid_i, md_result_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, md_mult_en_o, md_div_en_o,
           md_mult_sel_o, md_div_sel_o, md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o,
           md_data_ind_timing_o, md_ready_id_o, busy_o
  );
endinterface

// File: rtl/ibex_xif_multdiv_arbiter.sv
// ibex_xif_multdiv_arbiter: round-robin share of one multdiv unit between ID/EX (0) and XIF (1).
// Optional flush support via kill_i is enabled by defining IBEX_XIF_MD_KILL_EN.
module ibex_xif_multdiv_arbiter #(
  parameter int unsigned TagW          = 3,
  parameter bit          DataIndTiming = 1'b0
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  ibex_xif_multdiv_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e          r_state, w_state_nxt;
  logic            r_last, r_owner;
  logic [1:0]      r_op, r_sm;
  logic [31:0]     r_a, r_b, r_res;
  logic [TagW-1:0] r_tag;
  logic [1:0]      w_valid;
  logic            w_win, w_accept, w_done, w_kill_own, w_is_mul;
`ifdef IBEX_XIF_MD_KILL_EN
  logic r_killed;
  assign w_valid    = bus.req_valid_i & ~bus.kill_i;
  assign w_kill_own = r_killed | bus.kill_i[r_owner];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_killed <= 1'b0;
    else r_killed <= (w_state_nxt == IDLE) ? 1'b0 : (r_state == BUSY && bus.kill_i[r_owner]) ? 1'b1 : r_killed;
  end
`else
  logic w_unused;
  assign w_unused   = ^bus.kill_i;
  assign w_valid    = bus.req_valid_i;
  assign w_kill_own = 1'b0;
`endif
  // on contention the requester that did not win last time gets the unit
  assign w_win    = &w_valid ? ~r_last : w_valid[1];
  assign w_accept = rst_ni && r_state == IDLE && |w_valid;
  assign w_done   = r_state == BUSY && bus.md_valid_i;
  assign w_is_mul = ~r_op[1];
  always_comb begin
    w_state_nxt       = r_state;
    bus.req_ready_o   = 2'b00;
    bus.rsp_valid_o   = 2'b00;
    bus.md_ready_id_o = 1'b0;
    bus.md_mult_en_o  = 1'b0;
    bus.md_mult_sel_o = 1'b0;
    bus.md_div_en_o   = 1'b0;
    bus.md_div_sel_o  = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready_o = w_accept ? {w_win, ~w_win} : 2'b00;
        w_state_nxt     = w_accept ? BUSY : IDLE;
      end
      BUSY: begin
        bus.md_mult_en_o  = w_is_mul;
        bus.md_mult_sel_o = w_is_mul;
        bus.md_div_en_o   = ~w_is_mul;
        bus.md_div_sel_o  = ~w_is_mul;
        bus.md_ready_id_o = bus.md_valid_i;
        w_state_nxt       = !bus.md_valid_i ? BUSY : w_kill_own ? IDLE : RESP;
      end
      RESP: begin
        bus.rsp_valid_o = w_kill_own ? 2'b00 : {r_owner, ~r_owner};
        w_state_nxt     = (bus.rsp_ready_i[r_owner] || w_kill_own) ? IDLE : RESP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_op    <= '0;
      r_sm    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_tag   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_last  <= w_win;
        r_owner <= w_win;
        r_op    <= w_win ? bus.req_operator_i[3:2] : bus.req_operator_i[1:0];
        r_sm    <= w_win ? bus.req_signed_mode_i[3:2] : bus.req_signed_mode_i[1:0];
        r_a     <= w_win ? bus.req_op_a_i[63:32] : bus.req_op_a_i[31:0];
        r_b     <= w_win ? bus.req_op_b_i[63:32] : bus.req_op_b_i[31:0];
        r_tag   <= w_win ? bus.req_tag_i[2*TagW-1:TagW] : bus.req_tag_i[TagW-1:0];
      end
      if (w_done) r_res <= bus.md_result_i;
    end
  end
  assign bus.md_operator_o        = r_op;
  assign bus.md_signed_mode_o     = r_sm;
  assign bus.md_op_a_o            = r_a;
  assign bus.md_op_b_o            = r_b;
  assign bus.md_data_ind_timing_o = DataIndTiming;
  assign bus.rsp_result_o         = r_res;
  assign bus.rsp_tag_o            = r_tag;
  assign bus.busy_o               = r_state != IDLE;
endmodule

// File: doc/ibex_xif_multdiv_arbiter.md
Name: ibex_xif_multdiv_arbiter

Overview:
- Shares one slow multiplier/divider unit between two requesters: requester 0 is the core ID/EX path and requester 1 is the XIF coprocessor offload path.
- Arbitrates requests round-robin and registers the winning operands.
- Sequences the unit's enable/select/ready_id handshake until the unit signals valid.
- Captures the result and returns it to the winning requester over a valid/ready response channel.

Parameters:
- TagW, 3, width of the per-request tag echoed back with the result.
- DataIndTiming, 1'b0, value driven onto md_data_ind_timing_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  2  request valid; bit n belongs to requester n
- req_ready_o  out  2  request accepted (one-hot or zero)
- req_operator_i  in  4  md_op_e per requester; bits [2n+1:2n]
- req_signed_mode_i  in  4  signed_mode per requester; bits [2n+1:2n]
- req_op_a_i  in  64  operand A per requester; bits [32n+31:32n]
- req_op_b_i  in  64  operand B per requester; bits [32n+31:32n]
- req_tag_i  in  2*TagW  tag per requester
- kill_i  in  2  per-requester flush; used only with the optional feature
- rsp_valid_o  out  2  result valid to the owning requester (one-hot or zero)
- rsp_ready_i  in  2  requester accepts the result
- rsp_result_o  out  32  result, shared by both requesters
- rsp_tag_o  out  TagW  tag of the returned request
- md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o  out  1 each  unit enables and selects
- md_operator_o  out  2  operator to the unit
- md_signed_mode_o  out  2  signed mode to the unit
- md_op_a_o, md_op_b_o  out  32 each  operands to the unit
- md_data_ind_timing_o  out  1  equals DataIndTiming
- md_ready_id_o  out  1  result consumed; releases the unit's hold
- md_valid_i  in  1  unit result valid
- md_result_i  in  32  unit result
- busy_o  out  1  state != IDLE

Behaviour:
- FSM states and transitions:
  - IDLE: arbitrate.
  - IDLE -> BUSY on accept.
  - BUSY -> RESP when md_valid_i=1.
  - RESP -> IDLE when the owner's rsp_ready_i=1.
- Reset values:
  - State IDLE, last_grant=1 (so requester 0 wins first).
  - All registers zero.
  - All outputs 0 except md_data_ind_timing_o=DataIndTiming.
- Arbitration (IDLE only):
  - Exactly one valid request: it wins.
  - Both valid: the requester != last_grant wins.
  - req_ready_o is combinational, asserted for the winner only and only in IDLE.
  - On accept, register operator, signed_mode, op_a, op_b, tag and owner; update last_grant.
- Unit driving:
  - md_op_*, md_operator_o and md_signed_mode_o always come from the registered copies and stay stable for the whole operation.
  - In BUSY: mult_sel/mult_en=1 for MULL/MULH; div_sel/div_en=1 for DIV/REM.
  - In IDLE and RESP all four enables/selects are 0.
- Completion:
  - In BUSY with md_valid_i=1: md_ready_id_o=1 combinationally and md_result_i is registered in the same cycle, so the unit returns to its idle state.
  - md_ready_id_o=0 in all other cycles.
- Response:
  - In RESP, rsp_valid_o[owner]=1 with the registered result and tag.
  - rsp_result_o and rsp_tag_o are held stable while rsp_ready_i[owner]=0.
  - rsp_ready_i of the non-owner is ignored.
- Latency:
  - Accept at cycle 0; unit enabled from cycle 1.
  - rsp_valid one cycle after md_valid_i.
  - Next accept possible in the cycle after the response handshake. No accept occurs during RESP.
- Boundary cases:
  - Requests arriving in BUSY/RESP wait; they are not dropped.
  - md_valid_i outside BUSY is ignored.
  - Reset mid-operation returns to IDLE immediately; the unit shares rst_ni.

Optional Feature:
- Macro: IBEX_XIF_MD_KILL_EN.
- With the macro defined:
  - kill_i[owner] in BUSY sets a killed flag. The unit still runs to md_valid_i, which is acknowledged with md_ready_id_o=1, then the FSM goes directly to IDLE with no rsp_valid.
  - kill_i[owner] in RESP drops the response; the FSM goes to IDLE next cycle.
  - kill_i[n] in IDLE masks req_valid_i[n] for arbitration in that cycle.
  - The killed flag clears on entry to IDLE.
- Without the macro: kill_i is unused and has no effect.

Test Plan:
- Req0 MULL a=7, b=0xFFFFFFFD, signed_mode=2'b11, tag=5 -> rsp_valid_o=2'b01, result 0xFFFFFFEB, tag 5; md_ready_id_o pulses for exactly 1 cycle.
- Req1 DIV a=100, b=0 -> result 0xFFFFFFFF; req1 REM a=0xFFFFFFF9, b=2, signed -> result 0xFFFFFFFF.
- Both requests valid every cycle from reset -> grant order 0,1,0,1; each req_ready_o is a single-cycle pulse.
- Req0 DIVU 0x80000000/3 with rsp_ready_i=0 for 10 cycles -> result 0x2AAAAAAA held stable; req1 not accepted until the cycle after the handshake.
- rst_ni low while BUSY -> all outputs 0 asynchronously; after release, a new MULH 0x80000000*0x80000000 signed -> 0x40000000.
- With IBEX_XIF_MD_KILL_EN: kill_i[0] during BUSY of req0 -> no rsp_valid, md_ready_id_o still pulses; next req1 MULL 3*4 -> 12.
